key_filter_2ch: RTL and testbench
=================================

# key_filter_2ch

Two-channel push-button debouncer that turns raw, bouncing, active-low board keys into clean, synchronous, active-high logic levels.
- Drives the `a`/`b` inputs of the two-input gate stage directly downstream: `key_a` → `a`, `key_b` → `b`.
- Also emits a one-cycle press flag per channel for event-counting logic.

## Interface

Parameters:
- `CNT_MAX`, default 20'd999_999: last count value of the filter interval. The interval is CNT_MAX+1 cycles, i.e. 20 ms at 50 MHz. Benches use 9.
- `CNT_W`, default 20: counter width. Requires CNT_MAX < 2^CNT_W.

Ports:
- `sys_clk` input 1: system clock, 50 MHz. The only clock in the block.
- `sys_rst_n` input 1: reset, synchronous, active-low.
- `key_in` input 2: raw keys, asynchronous, 0 = pressed. Bit 0 is channel A, bit 1 is channel B.
- `key_a` output 1: debounced level of `key_in[0]`, 1 = pressed.
- `key_b` output 1: debounced level of `key_in[1]`, 1 = pressed.
- `key_flag` output 2: one-cycle pulse per channel on a confirmed press.

## Operation

- **Synchronizer:** each `key_in` bit passes through a 2-flop synchronizer (`sync1` → `sync2`). Both flops reset to 1 (released). Only `sync2` is used by the logic.
- **Per-channel FSM:** 4 states, fully independent per channel.
  - UP: stable released. If `sync2`=0, go to DN_FILT.
  - DN_FILT: counting a press.
    - If `sync2`=1, return to UP and clear `cnt`.
    - Else if `cnt`==CNT_MAX, go to DOWN and clear `cnt`.
    - Else `cnt`+1.
  - DOWN: stable pressed. If `sync2`=1, go to UP_FILT.
  - UP_FILT: counting a release.
    - If `sync2`=0, return to DOWN and clear `cnt`.
    - Else if `cnt`==CNT_MAX, go to UP and clear `cnt`.
    - Else `cnt`+1.
- **Counter:** the counter increments on the transition edge into a FILT state (value 1), so a level must differ from the stable state for CNT_MAX+1 consecutive `sync2` cycles to be accepted.
  - `cnt` never exceeds CNT_MAX and never wraps.
- **Glitches:** any glitch shorter than CNT_MAX+1 cycles is fully rejected. It produces no output change and no flag.
- **Outputs:** all registered.
  - `key_a`/`key_b` = 1 exactly while the channel is in DOWN or UP_FILT.
  - `key_flag[i]` = 1 for exactly one cycle, on the DN_FILT → DOWN transition, at the same edge `key_x` rises.
  - No flag is produced on release.
- **Independence:** channels do not interact. A simultaneous press on both channels gives simultaneous outputs and `key_flag`=2'b11.
- **Reset:** applied at any time, including mid-filter, reset returns both FSMs to UP.
  - All outputs go to 0, counters to 0, synchronizers to 1.
  - A key still held when reset is released needs a full new filter interval before it is accepted.

## Timing

- Edge k is the first rising edge that samples a new `key_in` level into `sync1`.
  - `sync2` updates at edge k+1.
  - `key_x` (and `key_flag` on a press) updates at edge k+2+CNT_MAX, provided the level held throughout.
- Latency is CNT_MAX+2 edges after edge k: 11 edges with CNT_MAX=9, about 20 ms with the default.
- Reset value of every output is 0: `key_a`=0, `key_b`=0, `key_flag`=2'b00.
- Reset takes effect at the first rising edge with `sys_rst_n`=0. Outputs read 0 from that edge onward.
- No combinational path from `key_in` to any output.

## Test plan

All scenarios use CNT_MAX=9 and a 20 ns clock.

- **Reset:** `key_in`=2'b11, `sys_rst_n`=0 for 5 cycles then 1 → `key_a`=`key_b`=0 and `key_flag`=0 throughout and for 20 further cycles.
- **Clean press A:** `key_in[0]` 1→0, held 40 cycles.
  - `key_a` rises exactly 11 edges after edge k.
  - `key_flag` is 2'b01 for exactly that one cycle.
  - `key_b` stays 0.
- **Bounce B:** `key_in[1]` low 5 cycles, high 3, low 7, high 2, then low stable.
  - No output change during the bounce.
  - `key_b` rises and `key_flag[1]` pulses once, 11 edges after the final falling sample.
- **Simultaneous press:** both keys 1→0 in the same cycle, held.
  - `key_a` and `key_b` rise at the same edge with `key_flag`=2'b11 for one cycle.
  - Downstream a&b = 1 from that edge.
- **Release filtering:** with A held, `key_in[0]` high 8 cycles then low → `key_a` stays 1. Then high stable → `key_a` falls 11 edges later, with no `key_flag` pulse.
- **Reset mid-filter:** press A, assert `sys_rst_n`=0 for 2 cycles at `cnt`=5, keep A pressed.
  - `key_a` remains 0 through the reset.
  - `key_a` rises 11 edges after the first post-reset edge that samples A low.

Source files
------------

// File: rtl/key_filter_2ch.sv
// Two-channel push-button debouncer: active-low raw keys in, clean active-high
// levels and one-cycle press flags out, all registered.
module key_filter_2ch #(
    parameter int unsigned CNT_MAX = 999_999,
    parameter int unsigned CNT_W   = 20
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [1:0] key_in,
    output logic       key_a,
    output logic       key_b,
    output logic [1:0] key_flag
);

    localparam int unsigned NCH = 2;

    typedef enum logic [1:0] {
        ST_UP      = 2'd0,
        ST_DN_FILT = 2'd1,
        ST_DOWN    = 2'd2,
        ST_UP_FILT = 2'd3
    } state_t;

    logic [NCH-1:0] sync1;
    logic [NCH-1:0] sync2;
    logic [NCH-1:0] level_vec;
    logic [NCH-1:0] flag_vec;

    // Two-flop synchronizer; idles at 1 (released)
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            sync1 <= {NCH{1'b1}};
            sync2 <= {NCH{1'b1}};
        end else begin
            sync1 <= key_in;
            sync2 <= sync1;
        end
    end

    for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
        state_t           state;
        state_t           state_nxt;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_nxt;
        logic             level_c;
        logic             flag_c;
        logic             level_q;
        logic             flag_q;
        logic             hit_max;

        assign hit_max = (cnt == CNT_W'(CNT_MAX));

        // State and counter register
        always_ff @(posedge sys_clk) begin
            if (!sys_rst_n) begin
                state <= ST_UP;
                cnt   <= '0;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
            end
        end

        // Next state; entering a FILT state counts as the first sample (cnt=1)
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            case (state)
                ST_UP: begin
                    if (!sync2[ch]) begin
                        state_nxt = ST_DN_FILT;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
                ST_DN_FILT: begin
                    if (sync2[ch]) begin
                        state_nxt = ST_UP;
                        cnt_nxt   = '0;
                    end else if (hit_max) begin
                        state_nxt = ST_DOWN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                ST_DOWN: begin
                    if (sync2[ch]) begin
                        state_nxt = ST_UP_FILT;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
                ST_UP_FILT: begin
                    if (!sync2[ch]) begin
                        state_nxt = ST_DOWN;
                        cnt_nxt   = '0;
                    end else if (hit_max) begin
                        state_nxt = ST_UP;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = ST_UP;
                    cnt_nxt   = '0;
                end
            endcase
        end

        // Output decode from the upcoming state so outputs change with the state
        always_comb begin
            level_c = 1'b0;
            flag_c  = 1'b0;
            if ((state_nxt == ST_DOWN) || (state_nxt == ST_UP_FILT)) begin
                level_c = 1'b1;
            end
            if ((state == ST_DN_FILT) && (state_nxt == ST_DOWN)) begin
                flag_c = 1'b1;
            end
        end

        always_ff @(posedge sys_clk) begin
            if (!sys_rst_n) begin
                level_q <= 1'b0;
                flag_q  <= 1'b0;
            end else begin
                level_q <= level_c;
                flag_q  <= flag_c;
            end
        end

        assign level_vec[ch] = level_q;
        assign flag_vec[ch]  = flag_q;
    end

    assign key_a    = level_vec[0];
    assign key_b    = level_vec[1];
    assign key_flag = flag_vec;

endmodule

// File: tb/tb_key_filter_2ch.sv
// Bench for key_filter_2ch: directed scenarios plus random key activity,
// all checked every cycle against a sample-run reference model.
module tb_key_filter_2ch;

    localparam int unsigned CNT_MAX = 9;
    localparam int unsigned CNT_W   = 20;
    localparam int          LAT     = CNT_MAX + 2;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic [1:0] key_in = 2'b11;
    logic       key_a;
    logic       key_b;
    logic [1:0] key_flag;

    int n_total = 0;
    int n_bad   = 0;

    key_filter_2ch #(
        .CNT_MAX (CNT_MAX),
        .CNT_W   (CNT_W)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key_in    (key_in),
        .key_a     (key_a),
        .key_b     (key_b),
        .key_flag  (key_flag)
    );

    always #10 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: a key level is accepted once the synchronized sample has
    // disagreed with the accepted level for CNT_MAX+1 consecutive cycles.
    logic [1:0] m_s1 = 2'b11;
    logic [1:0] m_s2 = 2'b11;
    logic [1:0] acc = 2'b00;
    logic [1:0] exp_flag = 2'b00;
    int         run [2];
    logic       chk_en = 1'b0;

    always @(posedge sys_clk) begin
        chk_en <= 1'b1;
        if (!sys_rst_n) begin
            m_s1     <= 2'b11;
            m_s2     <= 2'b11;
            acc      <= 2'b00;
            exp_flag <= 2'b00;
            run[0]   <= 0;
            run[1]   <= 0;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                if ((!m_s2[ch]) != acc[ch]) begin
                    if (run[ch] == CNT_MAX) begin
                        acc[ch]      <= !acc[ch];
                        run[ch]      <= 0;
                        exp_flag[ch] <= !acc[ch];
                    end else begin
                        run[ch]      <= run[ch] + 1;
                        exp_flag[ch] <= 1'b0;
                    end
                end else begin
                    run[ch]      <= 0;
                    exp_flag[ch] <= 1'b0;
                end
            end
            m_s2 <= m_s1;
            m_s1 <= key_in;
        end
    end

    always @(negedge sys_clk) begin
        if (chk_en) begin
            check("key_a", 32'(key_a), 32'(acc[0]));
            check("key_b", 32'(key_b), 32'(acc[1]));
            check("key_flag", 32'(key_flag), 32'(exp_flag));
        end
    end

    // Count edges from edge k (first posedge after the drive) until the
    // channel level equals want; flags captured at that edge.
    task automatic measure(input int ch, input logic want, output int n, output logic [1:0] flg);
        logic lvl;
        n   = -1;
        flg = 2'bxx;
        @(posedge sys_clk);
        for (int i = 1; i <= 40; i++) begin
            @(posedge sys_clk);
            #1;
            lvl = (ch == 0) ? key_a : key_b;
            if (lvl == want) begin
                n   = i;
                flg = key_flag;
                break;
            end
        end
        @(negedge sys_clk);
    endtask

    task automatic hold(input logic [1:0] v, input int cycles);
        key_in = v;
        repeat (cycles) @(negedge sys_clk);
    endtask

    int         n;
    logic [1:0] flg;
    int         rem [2];
    logic [1:0] lvl_r;

    initial begin
        // Reset with keys released
        @(negedge sys_clk);
        hold(2'b11, 5);
        sys_rst_n = 1'b1;
        check("rst_out", {29'd0, key_a, key_b, key_flag[0]}, 32'd0);
        hold(2'b11, 20);
        check("rst_idle", {28'd0, key_a, key_b, key_flag}, 32'd0);

        // Clean press on A
        key_in = 2'b10;
        measure(0, 1'b1, n, flg);
        check("lat_press_a", 32'(n), 32'(LAT));
        check("flag_press_a", 32'(flg), 32'd1);
        check("b_idle", 32'(key_b), 32'd0);
        hold(2'b10, 40);
        hold(2'b11, 25);

        // Bouncing press on B
        hold(2'b01, 5);
        hold(2'b11, 3);
        hold(2'b01, 7);
        hold(2'b11, 2);
        check("bounce_b", 32'(key_b), 32'd0);
        key_in = 2'b01;
        measure(1, 1'b1, n, flg);
        check("lat_press_b", 32'(n), 32'(LAT));
        check("flag_press_b", 32'(flg), 32'd2);
        hold(2'b01, 20);
        hold(2'b11, 25);

        // Simultaneous press
        key_in = 2'b00;
        measure(0, 1'b1, n, flg);
        check("lat_both", 32'(n), 32'(LAT));
        check("flag_both", 32'(flg), 32'd3);
        check("and_both", 32'(key_a & key_b), 32'd1);
        hold(2'b00, 20);
        hold(2'b11, 25);

        // Release filtering on A
        hold(2'b10, 25);
        hold(2'b11, 8);
        hold(2'b10, 15);
        check("rel_glitch_a", 32'(key_a), 32'd1);
        key_in = 2'b11;
        measure(0, 1'b0, n, flg);
        check("lat_release_a", 32'(n), 32'(LAT));
        check("flag_release_a", 32'(flg), 32'd0);
        hold(2'b11, 20);

        // Reset in the middle of a press filter (cnt=5)
        key_in = 2'b10;
        repeat (7) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        check("midrst_a", 32'(key_a), 32'd0);
        sys_rst_n = 1'b1;
        measure(0, 1'b1, n, flg);
        check("lat_after_rst", 32'(n), 32'(LAT));
        hold(2'b10, 10);
        hold(2'b11, 25);

        // Random key activity with occasional reset
        rem[0] = 1;
        rem[1] = 1;
        lvl_r  = 2'b11;
        for (int c = 0; c < 3000; c++) begin
            for (int ch = 0; ch < 2; ch++) begin
                rem[ch]--;
                if (rem[ch] <= 0) begin
                    lvl_r[ch] = !lvl_r[ch];
                    rem[ch]   = int'($urandom_range(1, 25));
                end
            end
            key_in    = lvl_r;
            sys_rst_n = ($urandom_range(0, 399) != 0);
            @(negedge sys_clk);
        end
        sys_rst_n = 1'b1;
        hold(2'b11, 25);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
